// File: rtl/vga_frame_reader_if.sv
// Frame buffer read port and VGA pin bundle for vga_frame_reader.
// The reader drives the address and the pins; the frame buffer returns data.
interface vga_frame_reader_if;
  logic [16:0] rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank_n;
  logic        frame_start;

  modport master (
    output rd_addr,
    input  rd_data,
    output vga_r, vga_g, vga_b,
    output vga_hsync, vga_vsync, vga_blank_n, frame_start
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  vga_r, vga_g, vga_b,
    input  vga_hsync, vga_vsync, vga_blank_n, frame_start
  );
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out of a 320x240 RGB565 frame buffer with 2x pixel/line
// doubling; syncs, blank and frame_start are delayed to match the RAM read latency.
module vga_frame_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int RAM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  vga_frame_reader_if.master bus
);

  localparam int STAGES = RAM_LATENCY + 2;

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_C = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_SS_C   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_C = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_SS_C   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_C   = 10'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              vld_p0;
  logic              hs_p0;
  logic              vs_p0;
  logic              sof_p0;
  logic [16:0]       row_p0;
  logic [16:0]       col_p0;
  logic [16:0]       addr_p0;
  logic [STAGES-1:0] vld_pipe;
  logic [STAGES-1:0] hs_pipe;
  logic [STAGES-1:0] vs_pipe;
  logic [STAGES-1:0] sof_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST_C) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // ---- stage 0: raw timing and source address from the counters ----
  assign vld_p0  = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_p0   = !((h_cnt >= H_SS_C) && (h_cnt < H_SE_C));
  assign vs_p0   = !((v_cnt >= V_SS_C) && (v_cnt < V_SE_C));
  assign sof_p0  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign row_p0  = {8'd0, v_cnt[9:1]};
  assign col_p0  = {8'd0, h_cnt[9:1]};
  assign addr_p0 = (row_p0 << 8) + (row_p0 << 6) + col_p0;

  // ---- stage 1: registered read address; timing enters the delay line ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_addr <= '0;
      vld_pipe    <= '0;
      hs_pipe     <= '1;
      vs_pipe     <= '1;
      sof_pipe    <= '0;
    end else begin
      bus.rd_addr <= vld_p0 ? addr_p0 : '0;
      vld_pipe    <= {vld_pipe[STAGES-2:0], vld_p0};
      hs_pipe     <= {hs_pipe[STAGES-2:0], hs_p0};
      vs_pipe     <= {vs_pipe[STAGES-2:0], vs_p0};
      sof_pipe    <= {sof_pipe[STAGES-2:0], sof_p0};
    end
  end

  // ---- stage RAM_LATENCY+2: colour capture, aligned with the delayed timing ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vga_r <= '0;
      bus.vga_g <= '0;
      bus.vga_b <= '0;
    end else if (vld_pipe[RAM_LATENCY]) begin
      bus.vga_r <= expand5(bus.rd_data[15:11]);
      bus.vga_g <= expand6(bus.rd_data[10:5]);
      bus.vga_b <= expand5(bus.rd_data[4:0]);
    end else begin
      bus.vga_r <= '0;
      bus.vga_g <= '0;
      bus.vga_b <= '0;
    end
  end

  assign bus.vga_hsync   = hs_pipe[STAGES-1];
  assign bus.vga_vsync   = vs_pipe[STAGES-1];
  assign bus.vga_blank_n = vld_pipe[STAGES-1];
  assign bus.frame_start = sof_pipe[STAGES-1];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: three RAM latencies at full timing plus a
// short-frame instance so whole-frame timing fits in a brief run.
module tb_vga_frame_reader;

  logic clk = 1'b0;
  logic rst;
  logic ram_ones;

  always #20 clk = ~clk;

  vga_frame_reader_if bus0 ();
  vga_frame_reader_if bus1 ();
  vga_frame_reader_if bus2 ();
  vga_frame_reader_if bus3 ();

  vga_frame_reader #(.RAM_LATENCY(2)) u_main (.clk(clk), .rst(rst), .bus(bus0.master));
  vga_frame_reader #(.RAM_LATENCY(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus1.master));
  vga_frame_reader #(.RAM_LATENCY(3)) u_lat3 (.clk(clk), .rst(rst), .bus(bus2.master));
  vga_frame_reader #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .RAM_LATENCY(2))
    u_short (.clk(clk), .rst(rst), .bus(bus3.master));

  // {rd_addr[44:28], rgb[27:4], hsync[3], vsync[2], blank_n[1], frame_start[0]}
  logic [44:0] snap [4];
  assign snap[0] = {bus0.rd_addr, bus0.vga_r, bus0.vga_g, bus0.vga_b,
                    bus0.vga_hsync, bus0.vga_vsync, bus0.vga_blank_n, bus0.frame_start};
  assign snap[1] = {bus1.rd_addr, bus1.vga_r, bus1.vga_g, bus1.vga_b,
                    bus1.vga_hsync, bus1.vga_vsync, bus1.vga_blank_n, bus1.frame_start};
  assign snap[2] = {bus2.rd_addr, bus2.vga_r, bus2.vga_g, bus2.vga_b,
                    bus2.vga_hsync, bus2.vga_vsync, bus2.vga_blank_n, bus2.frame_start};
  assign snap[3] = {bus3.rd_addr, bus3.vga_r, bus3.vga_g, bus3.vga_b,
                    bus3.vga_hsync, bus3.vga_vsync, bus3.vga_blank_n, bus3.frame_start};

  function automatic logic [15:0] ram_f(input logic [16:0] a, input logic ones);
    if (ones) return 16'hFFFF;
    case (a)
      17'd0:   return 16'hF800;
      17'd1:   return 16'h07E0;
      17'd2:   return 16'h8410;
      17'd3:   return 16'h001F;
      17'd320: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Fixed-latency RAM model: address delayed by L edges selects the data.
  logic [16:0] adly [4][3];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      adly[i][0] <= snap[i][44:28];
      adly[i][1] <= adly[i][0];
      adly[i][2] <= adly[i][1];
    end
  end
  assign bus0.rd_data = ram_f(adly[0][1], ram_ones);
  assign bus1.rd_data = ram_f(adly[1][0], ram_ones);
  assign bus2.rd_data = ram_f(adly[2][2], ram_ones);
  assign bus3.rd_data = ram_f(adly[3][1], ram_ones);

  function automatic int lat(input int i);
    case (i)
      1:       return 1;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  typedef struct {
    int          k;
    logic [44:0] exp;
  } vec_t;

  typedef struct {
    int          dk;
    logic [25:0] exp;
  } al_t;

  vec_t tbl [22];
  al_t  atbl [5];

  int n_tests = 0;
  int n_fail  = 0;
  int k;
  int phase;
  int addr_bad = 0, tim_bad = 0, blank_bad = 0, ones_bad = 0;
  logic fs_seen [4];

  logic prev_hs0, prev_bn0;
  int   hs_fall_t = 0, bn_rise_t = 0, n_per = 0, n_wid = 0, n_gap = 0, n_run = 0;
  logic prev_bn3, prev_vs3;
  int   bn_fall_t3 = 0, vs_fall_t3 = 0, fs_t3 = 0, n_fsper = 0, bn_lines = 0;
  int   n_lines = 0, n_vsgap = 0, n_vswid = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [44:0] mk(input logic [16:0] a, input logic [23:0] rgb,
                                     input logic hs, input logic vs, input logic bn,
                                     input logic fs);
    return {a, rgb, hs, vs, bn, fs};
  endfunction

  task automatic check_reset_all();
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_vals[%0d]", i), 64'(snap[i]), 64'(mk(17'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0)));
  endtask

  task automatic cycle_checks();
    int idx, h, v, ea;
    logic vis;
    for (int e = 0; e < 22; e++)
      if (tbl[e].k == k) check($sformatf("main_vec k=%0d", k), 64'(snap[0]), 64'(tbl[e].exp));
    for (int i = 1; i <= 2; i++) begin
      for (int e = 0; e < 5; e++)
        if (k == lat(i) + 2 + atbl[e].dk)
          check($sformatf("align L=%0d k=%0d", lat(i), k), 64'({snap[i][27:4], snap[i][1:0]}), 64'(atbl[e].exp));
      if (k == 3) check($sformatf("addr L=%0d", lat(i)), 64'(snap[i][44:28]), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      if (!fs_seen[i] && snap[i][0]) begin
        fs_seen[i] = 1'b1;
        check($sformatf("fs_latency[%0d]", i), 64'(k), 64'(lat(i) + 2));
        check($sformatf("fs_blank[%0d]", i), 64'(snap[i][1]), 64'd1);
      end
      if (k == 40) check($sformatf("fs_seen[%0d]", i), 64'(fs_seen[i]), 64'd1);
    end
    // Reference model of the main instance: address from stage-0 position, pins 4 cycles later.
    idx = k - 1; h = idx % 800; v = (idx / 800) % 525;
    ea  = (h < 640 && v < 480) ? (v / 2) * 320 + h / 2 : 0;
    if (snap[0][44:28] != 17'(ea)) addr_bad++;
    if (k >= 4) begin
      idx = k - 4; h = idx % 800; v = (idx / 800) % 525;
      vis = (h < 640) && (v < 480);
      if (snap[0][3:0] != {!(h >= 656 && h < 752), !(v >= 490 && v < 492), vis, (h == 0 && v == 0)})
        tim_bad++;
    end
    if (phase == 1 && k >= 2010) begin
      if (!snap[0][1] && snap[0][27:4] != 24'h0) blank_bad++;
      if (snap[0][1] && snap[0][27:4] != 24'hFFFFFF) ones_bad++;
    end
    if (phase == 1) begin
      if (prev_hs0 && !snap[0][3]) begin
        if (hs_fall_t > 0 && n_per < 3) begin check("hsync_period", 64'(k - hs_fall_t), 64'd800); n_per++; end
        hs_fall_t = k;
      end
      if (!prev_hs0 && snap[0][3] && n_wid < 3) begin check("hsync_width", 64'(k - hs_fall_t), 64'd96); n_wid++; end
      if (!prev_bn0 && snap[0][1]) begin
        if (hs_fall_t > 0 && n_gap < 3) begin check("hsync_to_blank", 64'(k - hs_fall_t), 64'd144); n_gap++; end
        bn_rise_t = k;
      end
      if (prev_bn0 && !snap[0][1] && n_run < 3) begin check("blank_run", 64'(k - bn_rise_t), 64'd640); n_run++; end
      prev_hs0 = snap[0][3];
      prev_bn0 = snap[0][1];
      if (snap[3][0]) begin
        if (fs_t3 > 0 && n_fsper < 2) begin check("frame_period", 64'(k - fs_t3), 64'd12000); n_fsper++; end
        if (fs_t3 > 0 && n_lines < 2) begin check("visible_lines", 64'(bn_lines), 64'd8); n_lines++; end
        fs_t3 = k; bn_lines = 0;
      end
      if (!prev_bn3 && snap[3][1]) bn_lines++;
      if (prev_bn3 && !snap[3][1]) bn_fall_t3 = k;
      // Front porch of 2 lines plus the 160-cycle tail of the last visible line.
      if (prev_vs3 && !snap[3][2]) begin
        if (n_vsgap < 2) begin check("vsync_start", 64'(k - bn_fall_t3), 64'd1760); n_vsgap++; end
        vs_fall_t3 = k;
      end
      if (!prev_vs3 && snap[3][2] && n_vswid < 2) begin check("vsync_width", 64'(k - vs_fall_t3), 64'd1600); n_vswid++; end
      prev_bn3 = snap[3][1];
      prev_vs3 = snap[3][2];
    end
  endtask

  initial begin
    tbl[0]  = '{1,    mk(17'd0,   24'h000000, 1, 1, 0, 0)};
    tbl[1]  = '{3,    mk(17'd1,   24'h000000, 1, 1, 0, 0)};
    tbl[2]  = '{4,    mk(17'd1,   24'hFF0000, 1, 1, 1, 1)};
    tbl[3]  = '{5,    mk(17'd2,   24'hFF0000, 1, 1, 1, 0)};
    tbl[4]  = '{6,    mk(17'd2,   24'h00FF00, 1, 1, 1, 0)};
    tbl[5]  = '{8,    mk(17'd3,   24'h848284, 1, 1, 1, 0)};
    tbl[6]  = '{10,   mk(17'd4,   24'h0000FF, 1, 1, 1, 0)};
    tbl[7]  = '{12,   mk(17'd5,   24'h000000, 1, 1, 1, 0)};
    tbl[8]  = '{640,  mk(17'd319, 24'h000000, 1, 1, 1, 0)};
    tbl[9]  = '{641,  mk(17'd0,   24'h000000, 1, 1, 1, 0)};
    tbl[10] = '{643,  mk(17'd0,   24'h000000, 1, 1, 1, 0)};
    tbl[11] = '{644,  mk(17'd0,   24'h000000, 1, 1, 0, 0)};
    tbl[12] = '{659,  mk(17'd0,   24'h000000, 1, 1, 0, 0)};
    tbl[13] = '{660,  mk(17'd0,   24'h000000, 0, 1, 0, 0)};
    tbl[14] = '{755,  mk(17'd0,   24'h000000, 0, 1, 0, 0)};
    tbl[15] = '{756,  mk(17'd0,   24'h000000, 1, 1, 0, 0)};
    tbl[16] = '{801,  mk(17'd0,   24'h000000, 1, 1, 0, 0)};
    tbl[17] = '{804,  mk(17'd1,   24'hFF0000, 1, 1, 1, 0)};
    tbl[18] = '{1601, mk(17'd320, 24'h000000, 1, 1, 0, 0)};
    tbl[19] = '{1603, mk(17'd321, 24'h000000, 1, 1, 0, 0)};
    tbl[20] = '{1604, mk(17'd321, 24'h0000FF, 1, 1, 1, 0)};
    tbl[21] = '{1605, mk(17'd322, 24'h0000FF, 1, 1, 1, 0)};
    atbl[0] = '{-1, {24'h000000, 2'b00}};
    atbl[1] = '{0,  {24'hFF0000, 2'b11}};
    atbl[2] = '{2,  {24'h00FF00, 2'b10}};
    atbl[3] = '{4,  {24'h848284, 2'b10}};
    atbl[4] = '{6,  {24'h0000FF, 2'b10}};

    rst = 1'b1;
    ram_ones = 1'b0;
    prev_hs0 = 1'b1; prev_bn0 = 1'b0; prev_bn3 = 1'b0; prev_vs3 = 1'b1;
    for (int i = 0; i < 4; i++) fs_seen[i] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_reset_all();
    rst = 1'b0;

    // Free run: line and frame timing, address doubling, colour, then all-ones data.
    phase = 1;
    for (k = 1; k <= 28300; k++) begin
      @(posedge clk); #1;
      cycle_checks();
      if (k == 2000) ram_ones = 1'b1;
    end

    // Mid-frame reset: next edge must show reset values, then a clean restart.
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_all();
    ram_ones = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_reset_all();
    rst = 1'b0;
    phase = 2;
    for (int i = 0; i < 4; i++) fs_seen[i] = 1'b0;
    for (k = 1; k <= 1700; k++) begin
      @(posedge clk); #1;
      cycle_checks();
    end

    check("addr_model", 64'(addr_bad), 64'd0);
    check("timing_model", 64'(tim_bad), 64'd0);
    check("blank_forces_rgb0", 64'(blank_bad), 64'd0);
    check("ones_data", 64'(ones_bad), 64'd0);
    check("hsync_checks_done", 64'(n_per + n_wid + n_gap + n_run), 64'd12);
    check("frame_checks_done", 64'(n_fsper + n_lines + n_vsgap + n_vswid), 64'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
